// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common with the transmitter)
// and the default bit period for a 100 MHz clock at 115200 baud.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } uart_state_e;

    localparam int UART_DEFAULT_CLOCK_PER_BIT = 868;

endpackage : uart_pkg

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous RX pin; resets to the idle-high
// line level so reset never looks like a start bit.
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // next-value selection for the two synchronizer stages
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // synchronizer stage registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule : uart_sync2

// File: rtl/uart_receiver.sv
// UART receiver, 8N1, LSB first, mid-bit sampling. Define UART_RX_FRAME_ERR_EN
// to get a one-cycle frame_err strobe on a bad stop bit; otherwise it is tied 0.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLOCK_PER_BIT = UART_DEFAULT_CLOCK_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(CLOCK_PER_BIT);
    localparam logic [CW-1:0] HALF_CNT = CW'((CLOCK_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLOCK_PER_BIT - 1);

    logic          rx_s;
    uart_state_e   state_q,    state_d;
    logic [CW-1:0] clk_cnt_q,  clk_cnt_d;
    logic [2:0]    bit_idx_q,  bit_idx_d;
    logic [7:0]    shreg_q,    shreg_d;
    logic [7:0]    data_q,     data_d;
    logic          rx_valid_q, rx_valid_d;
`ifdef UART_RX_FRAME_ERR_EN
    logic          frame_err_q, frame_err_d;
`endif

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // next-state, counter, shift register and output strobe logic
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        rx_valid_d = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
        frame_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                clk_cnt_d = {CW{1'b0}};
                bit_idx_d = 3'd0;
                if (!rx_s) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                // a start bit that is gone by mid-bit was only a glitch
                if (clk_cnt_q == HALF_CNT) begin
                    clk_cnt_d = {CW{1'b0}};
                    if (!rx_s) begin
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1'b1);
                end
            end
            DATA: begin
                if (clk_cnt_q == FULL_CNT) begin
                    clk_cnt_d          = {CW{1'b0}};
                    shreg_d[bit_idx_q] = rx_s;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1'b1);
                end
            end
            STOP: begin
                if (clk_cnt_q == FULL_CNT) begin
                    clk_cnt_d = {CW{1'b0}};
                    state_d   = CLEANUP;
                    if (rx_s) begin
                        data_d     = shreg_q;
                        rx_valid_d = 1'b1;
                    end else begin
`ifdef UART_RX_FRAME_ERR_EN
                        frame_err_d = 1'b1;
`endif
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1'b1);
                end
            end
            CLEANUP: begin
                clk_cnt_d = {CW{1'b0}};
                bit_idx_d = 3'd0;
                shreg_d   = 8'h00;
                state_d   = IDLE;
            end
            default: begin
                clk_cnt_d = {CW{1'b0}};
                bit_idx_d = 3'd0;
                state_d   = IDLE;
            end
        endcase
    end

    // FSM, counters, shift register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            clk_cnt_q  <= {CW{1'b0}};
            bit_idx_q  <= 3'd0;
            shreg_q    <= 8'h00;
            data_q     <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

`ifdef UART_RX_FRAME_ERR_EN
    // registered framing-error strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

    assign data     = data_q;
    assign rx_valid = rx_valid_q;

endmodule : uart_receiver

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: frame-level reference model with an
// expected-event queue, directed scenarios and randomized traffic.
module tb_uart_receiver;

    localparam int CPB  = 16;
    localparam int HALF = (CPB - 1) / 2;
    localparam int LAT  = 2 + HALF + 1 + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       rx_valid;
    logic       frame_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        bit         err;
        logic [7:0] b;
        int         due;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        cmp_e;
    logic [7:0] model_data = 8'h00;
    int         valid_cnt  = 0;
    int         ferr_cnt   = 0;
    int         good_sent  = 0;
    int         last_strobe_cyc = 0;

    uart_receiver #(.CLOCK_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_win(input string nm, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Transmitter model: one 8N1 frame, LSB first, CPB cycles per bit.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        ev_t e;
        e.err = !stop_ok;
        e.b   = b;
        e.due = cyc + LAT;
        if (stop_ok) begin
            exp_q.push_back(e);
            good_sent++;
        end
`ifdef UART_RX_FRAME_ERR_EN
        else begin
            exp_q.push_back(e);
        end
`endif
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_ok;
        tick(CPB);
        rx = 1'b1;
    endtask

    task automatic glitch(input int len);
        rx = 1'b0;
        tick(len);
        rx = 1'b1;
        tick(CPB + 2);
    endtask

    // Compare process: strobes against the expected-event queue, data every cycle.
    always @(negedge clk) begin
        if (rst) begin
            model_data = 8'h00;
            chk("rst_data", data, 8'h00);
            chk("rst_valid", rx_valid, 1'b0);
            chk("rst_frame_err", frame_err, 1'b0);
        end else begin
            chk("valid_ferr_exclusive", rx_valid & frame_err, 1'b0);
            if (rx_valid) valid_cnt++;
            if (frame_err) ferr_cnt++;
            if (rx_valid || frame_err) begin
                last_strobe_cyc = cyc;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_strobe: valid=%0b frame_err=%0b data=%0h expected no strobe",
                             rx_valid, frame_err, data);
                end else begin
                    cmp_e = exp_q.pop_front();
                    chk("strobe_kind_frame_err", frame_err, cmp_e.err);
                    chk_win("strobe_latency", cyc, cmp_e.due - 1, cmp_e.due + 1);
                    if (!cmp_e.err) begin
                        chk("rx_byte", data, cmp_e.b);
                        model_data = cmp_e.b;
                    end
                end
            end
            chk("data_hold", data, model_data);
            if (exp_q.size() > 0 && cyc > exp_q[0].due + 1) begin
                total++;
                bad++;
                $display("FAIL missing_strobe: none by cycle %0d, expected byte %0h err=%0b by %0d",
                         cyc, exp_q[0].b, exp_q[0].err, exp_q[0].due + 1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start_cyc;
        int ferr_before;
        logic [7:0] rb;
        logic [7:0] b55;

        rst = 1'b1;
        rx  = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(3);

        // single byte 0xA5 with latency pinned against the hand-computed window
        start_cyc = cyc;
        send_frame(8'hA5, 1'b1);
        tick(CPB);
        chk("a5_data", data, 8'hA5);
        chk("a5_model", model_data, 8'hA5);
        chk_win("a5_latency", last_strobe_cyc - start_cyc, 153, 155);

        // back-to-back with no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        tick(CPB);
        chk("b2b_last_data", data, 8'hFF);

        // glitch is ignored; the following frame proves the FSM is idle again
        glitch(4);
        chk("glitch_data_kept", data, 8'hFF);
        send_frame(8'h5A, 1'b1);
        tick(CPB);
        chk("after_glitch_data", data, 8'h5A);

        // bad stop bit
        ferr_before = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        tick(2 * CPB);
        chk("bad_stop_data_kept", data, 8'h5A);
`ifdef UART_RX_FRAME_ERR_EN
        chk("bad_stop_ferr_count", ferr_cnt - ferr_before, 1);
`else
        chk("bad_stop_ferr_count", ferr_cnt - ferr_before, 0);
`endif

        // reset during bit 4 of 0x55, held until the frame has finished
        b55 = 8'h55;
        rx  = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = b55[i];
            tick(CPB);
        end
        rx = b55[4];
        tick(CPB / 2);
        rst = 1'b1;
        tick(CPB - CPB / 2);
        for (int i = 5; i < 8; i++) begin
            rx = b55[i];
            tick(CPB);
        end
        rx = 1'b1;
        tick(CPB);
        rst = 1'b0;
        tick(1);
        chk("post_reset_data", data, 8'h00);
        chk("post_reset_valid", rx_valid, 1'b0);
        tick(CPB);
        send_frame(8'hC3, 1'b1);
        tick(CPB);
        chk("after_reset_frame", data, 8'hC3);

        // loopback bytes from the transmitter model
        send_frame(8'h01, 1'b1);
        send_frame(8'h80, 1'b1);
        send_frame(8'h7E, 1'b1);
        tick(CPB);
        chk("loopback_last", data, 8'h7E);

        // randomized traffic: good frames, bad stops and glitches
        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = $urandom_range(0, 99);
            rb   = 8'($urandom);
            if (kind < 70) begin
                send_frame(rb, 1'b1);
                tick($urandom_range(0, 3));
            end else if (kind < 85) begin
                send_frame(rb, 1'b0);
                tick(CPB + $urandom_range(0, 4));
            end else begin
                glitch($urandom_range(1, 4));
            end
        end

        for (int i = 0; i < 4 * LAT && exp_q.size() > 0; i++) tick(1);
        tick(CPB);
        chk("queue_drained", exp_q.size(), 0);
        chk("valid_count", valid_cnt, good_sent);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_receiver

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver: 8 data bits, no parity, 1 stop bit, LSB first, idle-high line. It is the receive-side counterpart of the team's UART transmitter and uses the same bit timing: 100 MHz clock, 115200 baud, 868 clocks per bit. It sits between the board RX pin and the byte-consuming logic. Each accepted byte is presented on `data` with a one-cycle `rx_valid` strobe.

## Interface
- `CLOCK_PER_BIT`, default 868: clocks per bit period. Legal range is ≥ 8; 868 means 100 MHz / 115200 baud.
- `clk`  input  1  system clock. All state updates on its rising edge.
- `rst`  input  1  reset, asynchronous and active-high. Forces every register to its reset value.
- `rx`  input  1  serial line, asynchronous to `clk`, idles high.
- `data`  output  8  last correctly framed byte. Reset value 8'h00. Holds its value until the next good byte.
- `rx_valid`  output  1  one-cycle strobe when `data` has just been updated. Reset value 0.
- `frame_err`  output  1  one-cycle strobe on a bad stop bit. Reset value 0. Tied 0 when the feature is compiled out.

## Operation
- `rx` passes through a 2-flop synchronizer before use. Both flops reset to 1. All FSM decisions use the synchronized value `rx_s`.
- Bit counter `clk_cnt` has width `$clog2(CLOCK_PER_BIT)`. The bit index `bit_idx` is 3 bits. A shift register `shreg` is 8 bits.
- States and transitions:
  - IDLE: `clk_cnt`=0, `bit_idx`=0. If `rx_s`=0, go to START.
  - START: count up to `(CLOCK_PER_BIT-1)/2`, which is mid start bit. At that point, if `rx_s`=0, clear `clk_cnt` and go to DATA. If `rx_s`=1, treat it as a glitch and return to IDLE with no output.
  - DATA: count up to `CLOCK_PER_BIT-1`. At that point, write `shreg[bit_idx] <= rx_s`, clear `clk_cnt`, and increment `bit_idx`. After the sample at `bit_idx`=7, go to STOP. `bit_idx` wraps to 0.
  - STOP: count up to `CLOCK_PER_BIT-1`, then sample `rx_s`.
    - If it is 1: `data <= shreg` and `rx_valid` pulses.
    - If it is 0: `data` is unchanged and `frame_err` pulses (when the macro is defined).
    - In both cases go to CLEANUP.
  - CLEANUP: one cycle. Clear `clk_cnt`, `bit_idx` and `shreg`, then go to IDLE.
  - Any unused encoding goes to IDLE.
- `rx_valid` and `frame_err` are never high in the same cycle.
- A line still low after a framing error is not taken as a new start bit until CLEANUP→IDLE has passed. Such a line then re-enters START immediately; this is accepted behaviour.
- Reset mid-frame: on the next cycle the FSM is in IDLE and the outputs hold their reset values. The remainder of the interrupted frame may be misread as a new start bit only if a low level is present after reset. Such a frame is rejected by the START check or flagged by the STOP check.

## Timing
- Sampling points fall at mid-bit: half a period after the detected falling edge, then every `CLOCK_PER_BIT` cycles.
- Latency: `rx_valid` rises 2 (synchronizer) + `(CLOCK_PER_BIT-1)/2` + 1 + 9·`CLOCK_PER_BIT` cycles after the falling edge of `rx`, within ±1 cycle.
- Minimum frame-to-frame spacing: stop bit plus 1 cycle (CLEANUP). Back-to-back frames at the nominal baud rate must be received without loss.
- Tolerated baud mismatch: ±3% between the sender and `CLOCK_PER_BIT`.
- There is no back-pressure. The consumer must take `data` before the next `rx_valid`.

## Configuration
- `UART_RX_FRAME_ERR_EN`
  - Defined: a bad stop bit drives `frame_err` high for exactly one cycle.
  - Not defined: `frame_err` is a constant 0 and bad frames are silently dropped. `data` and `rx_valid` behave the same in both builds.

## Structure
- Shared package `uart_pkg` holds:
  - state encoding constants IDLE=0, START=1, DATA=2, STOP=3, CLEANUP=4, as 3 bits, shared with the transmitter;
  - `UART_DEFAULT_CLOCK_PER_BIT` = 868.
- One sub-module: `uart_sync2`, a parameter-free 2-flop synchronizer with reset value 1. The FSM, counters and shift register live in `uart_receiver`.

## Test plan
Benches run with `CLOCK_PER_BIT`=16 for speed. "Strobe" means a single-cycle pulse.
- Single byte: drive frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) → one `rx_valid` strobe with `data`=8'hA5, inside the latency window above.
- Back-to-back: frames 0x00 then 0xFF with no idle gap → two `rx_valid` strobes, `data`=8'h00 then 8'hFF.
- Glitch: pull `rx` low for 4 cycles, then high → no `rx_valid`, no `frame_err`, FSM back in IDLE.
- Bad stop: frame 0x3C with stop bit 0 → with the macro, one `frame_err` strobe and `data` still at its previous value; without the macro, no strobe on any output.
- Reset mid-frame: assert `rst` during bit 4 of 0x55, release, then send 0xC3 → `data`=8'h00 right after reset, then one `rx_valid` strobe with 8'hC3.
- Loopback: the team transmitter drives `rx` with `CLOCK_PER_BIT`=16 and bytes 0x01, 0x80, 0x7E → the same three bytes are received in order, with no `frame_err`.
